iob_soc_opencryptolinux_spram_arbiter: RTL and testbench
========================================================

# iob_soc_opencryptolinux_spram_arbiter

Merges the CPU instruction and data IOb native ports onto the single-port byte-enable main memory (`iob_ram_sp_be`) in `USE_SPRAM` builds. Sits between the SoC core's `i_*`/`d_*` memory ports and the `spram_*` wires. Grants at most one access per cycle under fixed data-first priority with an instruction starvation guard, or round-robin. Generates per-port `rvalid`/`rdata` from the memory's 1-cycle read latency.

## Interface
- `ADDR_W`, 16: word address width (`SRAM_ADDR_W-2`).
- `DATA_W`, 32: data width; `DATA_W/8` strobes.
- `RR_MODE`, 0: 0 = data-first with starvation guard; 1 = round-robin.
- `STARVE_MAX`, 4: consecutive data grants tolerated while instruction waits (1..15; `RR_MODE=0` only).
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `i_valid_i` / `d_valid_i` in 1: request valid.
- `i_addr_i` / `d_addr_i` in `ADDR_W`: word address.
- `i_wdata_i` / `d_wdata_i` in `DATA_W`: write data.
- `i_wstrb_i` / `d_wstrb_i` in `DATA_W/8`: byte strobes; all-zero = read.
- `i_ready_o` / `d_ready_o` out 1: request accepted this cycle.
- `i_rvalid_o` / `d_rvalid_o` out 1: read data valid.
- `i_rdata_o` / `d_rdata_o` out `DATA_W`: read data.
- `spram_en_o` out 1: memory enable.
- `spram_addr_o` out `ADDR_W`: memory address.
- `spram_we_o` out `DATA_W/8`: byte write enables.
- `spram_di_o` out `DATA_W`: write data.
- `spram_do_i` in `DATA_W`: memory read data, valid the cycle after `en` with `we=0`.

## Operation
- Grant is combinational each cycle. `X_ready_o = grant_X`. `spram_*` is muxed from the granted port. `spram_en_o = grant_i | grant_d`.
- Only one port requesting: that port is granted.
- Both requesting, `RR_MODE=1`: grant the port not granted most recently. The `last` register resets to "instruction", so data wins the first tie.
- Both requesting, `RR_MODE=0`: grant data unless `starve_cnt == STARVE_MAX`, in which case grant instruction.
  - `starve_cnt` (4 bits) increments on each cycle where data is granted while `i_valid_i` is high.
  - It clears on any instruction grant or when `i_valid_i` is low.
  - It saturates at `STARVE_MAX`.
- Requester contract: `valid`, `addr`, `wdata` and `wstrb` stay stable until `ready`. The arbiter does not latch requests.
- Read granted in cycle N (`wstrb == 0`):
  - `X_rvalid_o = 1` in cycle N+1 only.
  - `X_rdata_o = spram_do_i` in N+1.
  - A `rsel` register records the owner.
- Writes produce no `rvalid`.
- Non-owner `rdata_o` is driven 0.
- Throughput is 1 access per cycle; a response (N+1) and a new grant overlap freely.
- Reset:
  - While `rst_i` is high, no grant is issued: all `ready_o` = 0 and `spram_en_o` = 0.
  - `rvalid` registers clear; `starve_cnt` clears; `last` is set to instruction.
  - A read granted in the cycle before reset asserts produces no `rvalid`; the response is dropped.

## Timing
- Request → `ready`: 0 cycles (combinational) when granted.
- Read grant → `rvalid`/`rdata`: exactly 1 cycle.
- Write grant → memory updated at the end of the grant cycle.
- Worst-case instruction wait under continuous data traffic: `STARVE_MAX` cycles (`RR_MODE=0`) or 1 cycle (`RR_MODE=1`).
- Combinational paths: `valid`/`addr`/`wstrb` → `spram_*` and `ready_o`; `spram_do_i` → `rdata_o`.
- Registered state: `last`, `starve_cnt`, `i_rvq`, `d_rvq`.

## Structure
- Package `iob_soc_opencryptolinux_spram_pkg` holds:
  - `PORT_I = 1'b0` and `PORT_D = 1'b1`.
  - `STARVE_CNT_W = 4`.
- Sub-module `iob_soc_opencryptolinux_spram_grant` computes the pure grant decision and owns `last`/`starve_cnt`. Inputs: both valids and `rst_i`. Outputs: `grant_i`, `grant_d`.
- Top level: muxing, `rvalid`/`rsel` pipeline registers, `rdata` steering.

## Test plan
- Single data read, addr `0x0010` with memory word `0xDEADBEEF`:
  - `d_ready` in cycle N; `spram_addr=0x0010`, `we=0`.
  - `d_rvalid=1`, `d_rdata=0xDEADBEEF` in N+1; `i_rvalid` stays 0.
- Data write, `wstrb=4'b0011`, `wdata=0x12345678` to `0x0004` (old `0xAAAAAAAA`), then read:
  - Read returns `0xAAAA5678`.
  - No `rvalid` is issued for the write.
- Both ports continuously requesting reads, `RR_MODE=0`, `STARVE_MAX=4`:
  - Grant pattern is D,D,D,D,I repeating.
  - Each `rvalid` goes to the matching port one cycle later.
- Same stimulus with `RR_MODE=1`:
  - Grant pattern is D,I,D,I…
  - Data wins the first tie after reset.
- Back-to-back instruction reads `0x0,0x1,0x2` with no data traffic:
  - `ready` is high 3 consecutive cycles.
  - `i_rvalid` is high 3 consecutive cycles, with data in order.
- Data read granted in cycle N, `rst_i=1` in N+1:
  - `d_rvalid=0` in N+1.
  - All `ready`/`en` are 0 during reset.
  - First grant after reset is data on a tie.

Source files
------------

// File: rtl/iob_soc_opencryptolinux_spram_pkg.sv
// rtl/iob_soc_opencryptolinux_spram_pkg.sv - shared constants for the SPRAM arbiter
// Purpose: port identifiers and the starvation counter width, shared by the
// arbiter top and its grant sub-module.
package iob_soc_opencryptolinux_spram_pkg;

  typedef logic port_t;

  localparam port_t PORT_I = 1'b0;
  localparam port_t PORT_D = 1'b1;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/iob_soc_opencryptolinux_spram_grant.sv
// rtl/iob_soc_opencryptolinux_spram_grant.sv - instruction/data grant decision
// Purpose: picks at most one of the two requesters each cycle, either
// data-first with an instruction starvation guard or round-robin.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   i_valid_i, d_valid_i  request valids from instruction and data ports
//   grant_i, grant_d      combinational one-hot (or zero) grant
module iob_soc_opencryptolinux_spram_grant
  import iob_soc_opencryptolinux_spram_pkg::*;
#(
  parameter int RR_MODE    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_valid_i,
  input  logic d_valid_i,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  port_t                   last;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    // No grant at all while reset is held.
    if (!rst_i) begin
      if (d_valid_i && !i_valid_i) begin
        grant_d = 1'b1;
      end else if (i_valid_i && !d_valid_i) begin
        grant_i = 1'b1;
      end else if (i_valid_i && d_valid_i) begin
        if (RR_MODE != 0) begin
          if (last == PORT_D) grant_i = 1'b1;
          else                grant_d = 1'b1;
        end else begin
          if (starve_cnt == STARVE_LIM) grant_i = 1'b1;
          else                          grant_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last       <= PORT_I;
      starve_cnt <= '0;
    end else begin
      if (grant_i)      last <= PORT_I;
      else if (grant_d) last <= PORT_D;

      // Counts data grants that made a pending instruction wait.
      if (grant_i || !i_valid_i) begin
        starve_cnt <= '0;
      end else if (grant_d && starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_soc_opencryptolinux_spram_arbiter.sv
// rtl/iob_soc_opencryptolinux_spram_arbiter.sv - I/D port merge onto single-port RAM
// Purpose: muxes the CPU instruction and data IOb ports onto one byte-enable
// single-port RAM and steers the 1-cycle read response back to its owner.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   i_*/d_* valid/addr/wdata/wstrb  requests (wstrb == 0 means read)
//   i_*/d_* ready/rvalid/rdata      accept strobe and read response
//   spram_en/addr/we/di_o, do_i     memory side
module iob_soc_opencryptolinux_spram_arbiter
  import iob_soc_opencryptolinux_spram_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RR_MODE    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_valid_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic [DATA_W-1:0]   i_wdata_i,
  input  logic [DATA_W/8-1:0] i_wstrb_i,
  output logic                i_ready_o,
  output logic                i_rvalid_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  input  logic                d_valid_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic                d_ready_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                spram_en_o,
  output logic [ADDR_W-1:0]   spram_addr_o,
  output logic [DATA_W/8-1:0] spram_we_o,
  output logic [DATA_W-1:0]   spram_di_o,
  input  logic [DATA_W-1:0]   spram_do_i
);

  logic grant_i;
  logic grant_d;
  logic i_rvq;
  logic d_rvq;

  iob_soc_opencryptolinux_spram_grant #(
    .RR_MODE    (RR_MODE),
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_valid_i (i_valid_i),
    .d_valid_i (d_valid_i),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  assign i_ready_o  = grant_i;
  assign d_ready_o  = grant_d;
  assign spram_en_o = grant_i | grant_d;

  always_comb begin
    spram_addr_o = i_addr_i;
    spram_di_o   = i_wdata_i;
    spram_we_o   = '0;
    if (grant_d) begin
      spram_addr_o = d_addr_i;
      spram_di_o   = d_wdata_i;
      spram_we_o   = d_wstrb_i;
    end else if (grant_i) begin
      spram_we_o   = i_wstrb_i;
    end
  end

  // i_rvq/d_rvq together act as the response-owner select for the next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_rvq <= 1'b0;
      d_rvq <= 1'b0;
    end else begin
      i_rvq <= grant_i && (i_wstrb_i == '0);
      d_rvq <= grant_d && (d_wstrb_i == '0);
    end
  end

  // Masking with rst_i drops a response whose grant preceded reset.
  assign i_rvalid_o = i_rvq && !rst_i;
  assign d_rvalid_o = d_rvq && !rst_i;
  assign i_rdata_o  = i_rvalid_o ? spram_do_i : '0;
  assign d_rdata_o  = d_rvalid_o ? spram_do_i : '0;

endmodule

// File: tb/tb_iob_soc_opencryptolinux_spram_arbiter.sv
// tb/tb_iob_soc_opencryptolinux_spram_arbiter.sv - directed bench for the SPRAM arbiter
module tb_iob_soc_opencryptolinux_spram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, d_valid = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0;
  logic [31:0] i_wdata = '0, d_wdata = '0;
  logic [3:0]  i_wstrb = '0, d_wstrb = '0;

  // dut0: data-first, dut1: round-robin
  logic        i_ready0, i_rvalid0, d_ready0, d_rvalid0, en0;
  logic [31:0] i_rdata0, d_rdata0, di0, sdo0;
  logic [15:0] addr0;
  logic [3:0]  we0;
  logic        i_ready1, i_rvalid1, d_ready1, d_rvalid1, en1;
  logic [31:0] i_rdata1, d_rdata1, di1, sdo1;
  logic [15:0] addr1;
  logic [3:0]  we1;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iob_soc_opencryptolinux_spram_arbiter #(.RR_MODE(0), .STARVE_MAX(4)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .i_valid_i(i_valid), .i_addr_i(i_addr), .i_wdata_i(i_wdata), .i_wstrb_i(i_wstrb),
    .i_ready_o(i_ready0), .i_rvalid_o(i_rvalid0), .i_rdata_o(i_rdata0),
    .d_valid_i(d_valid), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
    .d_ready_o(d_ready0), .d_rvalid_o(d_rvalid0), .d_rdata_o(d_rdata0),
    .spram_en_o(en0), .spram_addr_o(addr0), .spram_we_o(we0), .spram_di_o(di0),
    .spram_do_i(sdo0)
  );

  iob_soc_opencryptolinux_spram_arbiter #(.RR_MODE(1), .STARVE_MAX(4)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .i_valid_i(i_valid), .i_addr_i(i_addr), .i_wdata_i(i_wdata), .i_wstrb_i(i_wstrb),
    .i_ready_o(i_ready1), .i_rvalid_o(i_rvalid1), .i_rdata_o(i_rdata1),
    .d_valid_i(d_valid), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
    .d_ready_o(d_ready1), .d_rvalid_o(d_rvalid1), .d_rdata_o(d_rdata1),
    .spram_en_o(en1), .spram_addr_o(addr1), .spram_we_o(we1), .spram_di_o(di1),
    .spram_do_i(sdo1)
  );

  // Read-first single-port byte-enable RAM models, 1-cycle read latency.
  always @(posedge clk) begin
    if (en0) begin
      for (int b = 0; b < 4; b++)
        if (we0[b]) mem0[addr0[7:0]][b*8 +: 8] <= di0[b*8 +: 8];
      sdo0 <= mem0[addr0[7:0]];
    end
    if (en1) begin
      for (int b = 0; b < 4; b++)
        if (we1[b]) mem1[addr1[7:0]][b*8 +: 8] <= di1[b*8 +: 8];
      sdo1 <= mem1[addr1[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] idat [0:2];
  logic        pat0 [0:9];
  logic        pat1 [0:9];
  logic        prev0, prev1;

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem0[k] = 32'h0;
      mem1[k] = 32'h0;
    end
    mem0[16] = 32'hDEADBEEF; mem1[16] = 32'hDEADBEEF;
    mem0[4]  = 32'hAAAAAAAA; mem1[4]  = 32'hAAAAAAAA;
    idat[0] = 32'h11110000; idat[1] = 32'h22221111; idat[2] = 32'h33332222;
    for (int k = 0; k < 3; k++) begin
      mem0[k] = idat[k];
      mem1[k] = idat[k];
    end
    // 1 = data grant
    pat0[0]=1; pat0[1]=1; pat0[2]=1; pat0[3]=1; pat0[4]=0;
    pat0[5]=1; pat0[6]=1; pat0[7]=1; pat0[8]=1; pat0[9]=0;
    for (int k = 0; k < 10; k++) pat1[k] = (k % 2 == 0);

    // Reset held with both ports requesting: nothing granted.
    i_valid = 1'b1; d_valid = 1'b1; d_addr = 16'h0010;
    @(negedge clk);
    chk("rst_i_ready0", {31'b0, i_ready0}, 32'd0);
    chk("rst_d_ready0", {31'b0, d_ready0}, 32'd0);
    chk("rst_en0",      {31'b0, en0},      32'd0);
    chk("rst_en1",      {31'b0, en1},      32'd0);
    step();
    chk("rst_rvalid", {30'b0, i_rvalid0, d_rvalid0}, 32'd0);
    rst = 1'b0;

    // Both ports continuously reading.
    prev0 = 1'b0; prev1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("pat0_d_%0d", k), {31'b0, d_ready0}, {31'b0, pat0[k]});
      chk($sformatf("pat0_i_%0d", k), {31'b0, i_ready0}, {31'b0, !pat0[k]});
      chk($sformatf("pat1_d_%0d", k), {31'b0, d_ready1}, {31'b0, pat1[k]});
      chk($sformatf("pat1_i_%0d", k), {31'b0, i_ready1}, {31'b0, !pat1[k]});
      if (k > 0) begin
        chk($sformatf("rv0_%0d", k), {30'b0, d_rvalid0, i_rvalid0}, {30'b0, prev0, !prev0});
        chk($sformatf("rv1_%0d", k), {30'b0, d_rvalid1, i_rvalid1}, {30'b0, prev1, !prev1});
        chk($sformatf("rd0_%0d", k), prev0 ? d_rdata0 : i_rdata0,
            prev0 ? 32'hDEADBEEF : 32'h11110000);
      end
      prev0 = pat0[k];
      prev1 = pat1[k];
      step();
    end
    i_valid = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    chk("pat_tail_rv0", {30'b0, d_rvalid0, i_rvalid0}, 32'd1);
    step();

    // Single data read.
    d_valid = 1'b1; d_addr = 16'h0010; d_wstrb = 4'b0000;
    @(negedge clk);
    chk("rd_d_ready", {31'b0, d_ready0}, 32'd1);
    chk("rd_addr",    {16'b0, addr0},    32'h0010);
    chk("rd_we",      {28'b0, we0},      32'd0);
    step();
    d_valid = 1'b0;
    @(negedge clk);
    chk("rd_d_rvalid", {31'b0, d_rvalid0}, 32'd1);
    chk("rd_d_rdata",  d_rdata0,           32'hDEADBEEF);
    chk("rd_i_rvalid", {31'b0, i_rvalid0}, 32'd0);
    chk("rd_i_rdata",  i_rdata0,           32'd0);
    step();

    // Partial write then read back.
    d_valid = 1'b1; d_addr = 16'h0004; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    @(negedge clk);
    chk("wr_d_ready", {31'b0, d_ready0}, 32'd1);
    chk("wr_we",      {28'b0, we0},      32'h3);
    chk("wr_di",      di0,               32'h12345678);
    step();
    d_wstrb = 4'b0000; d_wdata = 32'h0;
    @(negedge clk);
    chk("wr_no_rvalid", {31'b0, d_rvalid0}, 32'd0);
    step();
    d_valid = 1'b0;
    @(negedge clk);
    chk("wr_rb_rvalid", {31'b0, d_rvalid0}, 32'd1);
    chk("wr_rb_rdata",  d_rdata0,           32'hAAAA5678);
    step();

    // Back-to-back instruction reads.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        i_valid = 1'b1; i_addr = 16'(k);
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 3) chk($sformatf("ib_ready_%0d", k), {31'b0, i_ready0}, 32'd1);
      if (k > 0) begin
        chk($sformatf("ib_rvalid_%0d", k), {31'b0, i_rvalid0}, 32'd1);
        chk($sformatf("ib_rdata_%0d", k),  i_rdata0,           idat[k-1]);
      end
      step();
    end

    // Data read immediately followed by reset: response dropped.
    d_valid = 1'b1; d_addr = 16'h0010;
    @(negedge clk);
    chk("rr_d_ready", {31'b0, d_ready0}, 32'd1);
    step();
    rst = 1'b1; i_valid = 1'b1;
    @(negedge clk);
    chk("rr_d_rvalid0", {31'b0, d_rvalid0}, 32'd0);
    chk("rr_d_rvalid1", {31'b0, d_rvalid1}, 32'd0);
    chk("rr_ready0",    {30'b0, i_ready0, d_ready0}, 32'd0);
    chk("rr_ready1",    {30'b0, i_ready1, d_ready1}, 32'd0);
    chk("rr_en",        {30'b0, en0, en1}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rr_first0", {30'b0, d_ready0, i_ready0}, 32'd2);
    chk("rr_first1", {30'b0, d_ready1, i_ready1}, 32'd2);
    step();
    i_valid = 1'b0; d_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
